// File: rtl/jtag_pkg.sv
// jtag_pkg: shared encodings for the JTAG host controller.
//   - TAP controller state encodings (IEEE 1149.1 style 4-bit codes)
//   - host command opcodes
//   - controller FSM state type
package jtag_pkg;

    localparam logic [3:0] TAP_EX2DR = 4'd0;
    localparam logic [3:0] TAP_EX1DR = 4'd1;
    localparam logic [3:0] TAP_SHDR  = 4'd2;
    localparam logic [3:0] TAP_PAUDR = 4'd3;
    localparam logic [3:0] TAP_SELIR = 4'd4;
    localparam logic [3:0] TAP_UPDDR = 4'd5;
    localparam logic [3:0] TAP_CAPDR = 4'd6;
    localparam logic [3:0] TAP_SELDR = 4'd7;
    localparam logic [3:0] TAP_EX2IR = 4'd8;
    localparam logic [3:0] TAP_EX1IR = 4'd9;
    localparam logic [3:0] TAP_SHIR  = 4'd10;
    localparam logic [3:0] TAP_PAUIR = 4'd11;
    localparam logic [3:0] TAP_RTI   = 4'd12;
    localparam logic [3:0] TAP_UPDIR = 4'd13;
    localparam logic [3:0] TAP_CAPIR = 4'd14;
    localparam logic [3:0] TAP_TLR   = 4'd15;

    localparam logic [1:0] OP_TAP_RESET = 2'd0;
    localparam logic [1:0] OP_SHIFT_IR  = 2'd1;
    localparam logic [1:0] OP_SHIFT_DR  = 2'd2;
    localparam logic [1:0] OP_IDLE_RUN  = 2'd3;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_HEAD, S_SHIFT, S_TAIL, S_RUN, S_RESP
    } ctl_state_t;

endpackage

// File: rtl/jtag_tap_tracker.sv
// jtag_tap_tracker: shadow copy of a TAP controller.
//   CLK, RESET (async, active-high) -- clock / reset (reset state is TLR)
//   tms                             -- TMS value presented to the TAP
//   adv                             -- one-cycle strobe on each TCK rising edge
//   tap_state                       -- current shadow TAP state (jtag_pkg encoding)
module jtag_tap_tracker
    import jtag_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       tms,
    input  logic       adv,
    output logic [3:0] tap_state
);

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
        logic [3:0] n;
        n = TAP_TLR;
        case (s)
            TAP_TLR:   n = m ? TAP_TLR   : TAP_RTI;
            TAP_RTI:   n = m ? TAP_SELDR : TAP_RTI;
            TAP_SELDR: n = m ? TAP_SELIR : TAP_CAPDR;
            TAP_CAPDR: n = m ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:  n = m ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR: n = m ? TAP_UPDDR : TAP_PAUDR;
            TAP_PAUDR: n = m ? TAP_EX2DR : TAP_PAUDR;
            TAP_EX2DR: n = m ? TAP_UPDDR : TAP_SHDR;
            TAP_UPDDR: n = m ? TAP_SELDR : TAP_RTI;
            TAP_SELIR: n = m ? TAP_TLR   : TAP_CAPIR;
            TAP_CAPIR: n = m ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:  n = m ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR: n = m ? TAP_UPDIR : TAP_PAUIR;
            TAP_PAUIR: n = m ? TAP_EX2IR : TAP_PAUIR;
            TAP_EX2IR: n = m ? TAP_UPDIR : TAP_SHIR;
            TAP_UPDIR: n = m ? TAP_SELDR : TAP_RTI;
            default:   n = TAP_TLR;
        endcase
        return n;
    endfunction

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)    tap_state <= TAP_TLR;
        else if (adv) tap_state <= tap_next(tap_state, tms);
    end

endmodule

// File: rtl/jtag_master.sv
// jtag_master: command-driven JTAG host controller.
//   CLK, RESET (async, active-high)
//   cmd_valid/cmd_ready, cmd_op, cmd_len, cmd_data -- host command (LSB of data shifted first)
//   rsp_valid/rsp_ready, rsp_data                  -- response, captured TDO (bit i = scan bit i)
//   tck, tms, tdi, tdo                             -- JTAG pins (tck idles low)
//   tap_state                                      -- shadow TAP state
//   busy                                           -- controller not idle
module jtag_master
    import jtag_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int MAX_BITS = 32,
    parameter int LEN_W    = 6
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [MAX_BITS-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [MAX_BITS-1:0] rsp_data,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo,
    output logic [3:0]          tap_state,
    output logic                busy
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int IDX_W = $clog2(MAX_BITS);

    ctl_state_t          state, state_n, follow;
    logic [LEN_W-1:0]    cnt, cnt_n, len, len_n, len_clamp, last_idx;
    logic [DIV_W-1:0]    div, div_n;
    logic                tck_n, tms_n, tdi_n;
    logic                is_ir, is_ir_n, from_cmd, from_cmd_n;
    logic [MAX_BITS-1:0] data, data_n, cap;
    logic                adv, load, accept;

    // tms/tdi for step i of a clocking state; also used with the
    // post-transition state so pins are set up on the falling edge.
    function automatic logic [1:0] step_bits(input ctl_state_t s, input logic [LEN_W-1:0] i,
                                             input logic ir, input logic [LEN_W-1:0] n,
                                             input logic [MAX_BITS-1:0] d);
        logic [1:0] b;
        b = 2'b00;
        case (s)
            S_INIT:  b = {i < LEN_W'(5), 1'b0};
            S_HEAD:  b = {(i == '0) || (ir && i == LEN_W'(1)), 1'b0};
            S_SHIFT: b = {i == n - LEN_W'(1), d[i[IDX_W-1:0]]};
            S_TAIL:  b = {i == '0, 1'b0};
            default: b = 2'b00;
        endcase
        return b;
    endfunction

    assign len_clamp = (cmd_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : cmd_len;

    always_comb begin
        last_idx = len - LEN_W'(1);
        follow   = S_RESP;
        case (state)
            S_INIT:  begin last_idx = LEN_W'(5); follow = from_cmd ? S_RESP : S_IDLE; end
            S_HEAD:  begin last_idx = is_ir ? LEN_W'(3) : LEN_W'(2); follow = S_SHIFT; end
            S_SHIFT: follow = S_TAIL;
            S_TAIL:  last_idx = LEN_W'(1);
            default: ;
        endcase
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        div_n      = div;
        tck_n      = tck;
        tms_n      = tms;
        tdi_n      = tdi;
        len_n      = len;
        data_n     = data;
        is_ir_n    = is_ir;
        from_cmd_n = from_cmd;
        adv        = 1'b0;
        load       = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    accept     = 1'b1;
                    load       = 1'b1;
                    cnt_n      = '0;
                    div_n      = '0;
                    len_n      = len_clamp;
                    data_n     = cmd_data;
                    is_ir_n    = (cmd_op == OP_SHIFT_IR);
                    from_cmd_n = (cmd_op == OP_TAP_RESET);
                    if (cmd_op == OP_TAP_RESET)     state_n = S_INIT;
                    else if (len_clamp == '0)       state_n = S_RESP;
                    else if (cmd_op == OP_IDLE_RUN) state_n = S_RUN;
                    else                            state_n = S_HEAD;
                end
            end
            S_RESP: if (rsp_ready) state_n = S_IDLE;
            default: begin
                // clocking states: CLK_DIV cycles low, CLK_DIV cycles high per bit
                if (div != DIV_W'(CLK_DIV - 1)) begin
                    div_n = div + 1'b1;
                end else begin
                    div_n = '0;
                    tck_n = ~tck;
                    if (!tck) begin
                        adv = 1'b1;
                    end else begin
                        load = 1'b1;
                        if (cnt == last_idx) begin
                            cnt_n   = '0;
                            state_n = follow;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                end
            end
        endcase
        if (load) {tms_n, tdi_n} = step_bits(state_n, cnt_n, is_ir_n, len_n, data_n);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= S_INIT;
            cnt      <= '0;
            div      <= '0;
            tck      <= 1'b0;
            tms      <= 1'b1;
            tdi      <= 1'b0;
            len      <= '0;
            data     <= '0;
            is_ir    <= 1'b0;
            from_cmd <= 1'b0;
            cap      <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            div      <= div_n;
            tck      <= tck_n;
            tms      <= tms_n;
            tdi      <= tdi_n;
            len      <= len_n;
            data     <= data_n;
            is_ir    <= is_ir_n;
            from_cmd <= from_cmd_n;
            if (accept)                      cap <= '0;
            else if (adv && state == S_SHIFT) cap[cnt[IDX_W-1:0]] <= tdo;
        end
    end

    assign cmd_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);
    assign rsp_data  = cap;

    jtag_tap_tracker u_tap (
        .CLK       (CLK),
        .RESET     (RESET),
        .tms       (tms),
        .adv       (adv),
        .tap_state (tap_state)
    );

endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: self-checking bench for jtag_master.
// A pin-level target TAP (BYPASS on DR, 4-bit IR capturing 0001) drives tdo;
// expected responses come from simple arithmetic on the command.
module tb_jtag_master;
    import jtag_pkg::*;

    localparam int CLK_DIV  = 2;
    localparam int MAX_BITS = 32;
    localparam int LEN_W    = 6;

    logic                CLK = 1'b0, RESET = 1'b0;
    logic                cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0]          cmd_op;
    logic [LEN_W-1:0]    cmd_len;
    logic [MAX_BITS-1:0] cmd_data, rsp_data;
    logic                tck, tms, tdi, tdo = 1'b0;
    logic [3:0]          tap_state;
    logic                busy;

    jtag_master #(.CLK_DIV(CLK_DIV), .MAX_BITS(MAX_BITS), .LEN_W(LEN_W)) dut (
        .CLK(CLK), .RESET(RESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .tap_state(tap_state), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int vectors = 0, miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // IEEE 1149.1 transition table, indexed by state code: next on tms=0 / tms=1
    int nx0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    int nx1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

    int       m_state = 15;
    logic     byp = 1'b0;
    logic [3:0] ir_sr = 4'd0;
    int       np = 0, nt = 0;
    logic     tms_log [1024];
    logic     tdi_log [1024];

    // target TAP: acts on tck rise, drives tdo on tck fall
    always @(posedge tck or posedge RESET) begin
        if (RESET) begin
            m_state <= 15;
            byp     <= 1'b0;
            ir_sr   <= 4'd0;
        end else begin
            np <= np + 1;
            tms_log[np % 1024] <= tms;
            if (m_state == 6)       byp <= 1'b0;
            else if (m_state == 2)  byp <= tdi;
            if (m_state == 14)      ir_sr <= 4'b0001;
            else if (m_state == 10) ir_sr <= {tdi, ir_sr[3:1]};
            if (m_state == 2 || m_state == 10) begin
                tdi_log[nt % 1024] <= tdi;
                nt <= nt + 1;
            end else begin
                chk("tdi_idle", 64'(tdi), 64'd0);
            end
            m_state <= tms ? nx1[m_state] : nx0[m_state];
        end
    end

    always @(negedge tck or posedge RESET) begin
        if (RESET) tdo <= 1'b0;
        else       tdo <= (m_state == 2) ? byp : (m_state == 10) ? ir_sr[0] : 1'b0;
    end

    int hi_run = 0;
    always @(negedge CLK) begin
        chk("tap_state", 64'(tap_state), 64'(m_state));
        if (RESET)       hi_run <= 0;
        else if (tck)    hi_run <= hi_run + 1;
        else if (hi_run != 0) begin
            chk("tck_high", 64'(hi_run), 64'(CLK_DIV));
            hi_run <= 0;
        end
    end

    task automatic wait_ready(output bit seen_rsp);
        int g;
        g = 0;
        seen_rsp = 0;
        while (!cmd_ready && g < 2000) begin
            @(negedge CLK);
            g++;
            if (rsp_valid) seen_rsp = 1;
        end
        chk("ready_timeout", 64'(g < 2000), 64'd1);
    endtask

    task automatic tms_seq(input int p0, input int k, input logic [63:0] exp, input string tag);
        logic [63:0] got;
        got = '0;
        for (int i = 0; i < 64 && i < np - p0; i++) got[i] = tms_log[(p0 + i) % 1024];
        chk({tag, "_tck_count"}, 64'(np - p0), 64'(k));
        chk({tag, "_tms_seq"}, got, exp);
    endtask

    // post-reset (or post-TAP_RESET-after-abort) init sequence check
    task automatic check_init(input int p0, input string tag);
        bit seen;
        wait_ready(seen);
        chk({tag, "_no_rsp"}, 64'(seen), 64'd0);
        tms_seq(p0, 6, 64'b011111, tag);
        chk({tag, "_tap_rti"}, 64'(tap_state), 64'd12);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_tck"}, 64'(tck), 64'd0);
        chk({tag, "_tms"}, 64'(tms), 64'd1);
        chk({tag, "_tdi"}, 64'(tdi), 64'd0);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
        chk({tag, "_tap"}, 64'(tap_state), 64'd15);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
    endtask

    task automatic run_cmd(input logic [1:0] op, input int len, input logic [31:0] data, input int hold);
        int p0, t0, nc, k, g;
        bit seen;
        logic [63:0] tms_exp, tdi_got, mask, rsp_exp;
        nc = (len > MAX_BITS) ? MAX_BITS : len;
        mask = (64'd1 << nc) - 64'd1;
        wait_ready(seen);
        p0 = np;
        t0 = nt;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = LEN_W'(len);
        cmd_data  = data;
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
        @(negedge CLK);
        chk("ready_drop", 64'(cmd_ready), 64'd0);
        g = 0;
        while (!rsp_valid && g < 2000) begin
            @(negedge CLK);
            g++;
        end
        chk("rsp_timeout", 64'(g < 2000), 64'd1);

        // expected tms stream and response from the command alone
        tms_exp = '0;
        k = 0;
        rsp_exp = '0;
        if (op == OP_TAP_RESET) begin
            for (int i = 0; i < 5; i++) begin tms_exp[k] = 1'b1; k++; end
            k++;
        end else if (nc > 0 && op == OP_IDLE_RUN) begin
            k = nc;
        end else if (nc > 0) begin
            tms_exp[k] = 1'b1; k++;
            if (op == OP_SHIFT_IR) begin tms_exp[k] = 1'b1; k++; end
            k += 2;
            k += nc - 1;
            tms_exp[k] = 1'b1; k++;
            tms_exp[k] = 1'b1; k++;
            k++;
            rsp_exp = (op == OP_SHIFT_DR) ? (({32'd0, data} << 1) & mask)
                                          : ((({32'd0, data} << 4) | 64'd1) & mask);
        end
        tms_seq(p0, k, tms_exp, "cmd");
        if ((op == OP_SHIFT_DR || op == OP_SHIFT_IR) && nc > 0) begin
            tdi_got = '0;
            for (int i = 0; i < 64 && i < nt - t0; i++) tdi_got[i] = tdi_log[(t0 + i) % 1024];
            chk("tdi_count", 64'(nt - t0), 64'(nc));
            chk("tdi_seq", tdi_got, {32'd0, data} & mask);
        end
        chk("rsp_data", 64'(rsp_data), rsp_exp);
        chk("tap_end", 64'(tap_state), 64'd12);
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            chk("rsp_hold", {30'd0, rsp_valid, cmd_ready, rsp_data}, {30'd0, 1'b1, 1'b0, rsp_exp[31:0]});
        end
        rsp_ready = 1'b1;
        @(posedge CLK);
        #1 rsp_ready = 1'b0;
        @(negedge CLK);
        chk("rsp_drop", 64'(rsp_valid), 64'd0);
        chk("ready_back", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        int p0, t0, g;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_len   = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        #1 RESET = 1'b1;
        repeat (3) @(negedge CLK);
        check_reset_values("rst");
        p0 = np;
        RESET = 1'b0;
        check_init(p0, "init");

        run_cmd(OP_SHIFT_DR, 8, 32'h5A, 0);
        run_cmd(OP_SHIFT_IR, 4, 32'hA, 0);
        run_cmd(OP_SHIFT_DR, 0, 32'hFFFF_FFFF, 0);
        run_cmd(OP_IDLE_RUN, 3, 32'h0, 0);
        run_cmd(OP_SHIFT_DR, 40, 32'hDEAD_BEEF, 20);
        run_cmd(OP_TAP_RESET, 7, 32'h1234, 2);
        run_cmd(OP_SHIFT_IR, 32, 32'h8000_0001, 1);

        // abort a 32-bit DR scan around bit 5
        wait_ready(g[0]);
        t0 = nt;
        cmd_valid = 1'b1;
        cmd_op    = OP_SHIFT_DR;
        cmd_len   = LEN_W'(32);
        cmd_data  = $urandom;
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
        g = 0;
        while (nt - t0 < 5 && g < 2000) begin
            @(negedge CLK);
            g++;
        end
        chk("abort_timeout", 64'(g < 2000), 64'd1);
        @(posedge CLK);
        #2 RESET = 1'b1;
        #1 check_reset_values("abort");
        repeat (2) @(negedge CLK);
        p0 = np;
        RESET = 1'b0;
        check_init(p0, "reinit");

        for (int n = 0; n < 40; n++) begin
            run_cmd(2'($urandom_range(0, 3)), int'($urandom_range(0, 63)), $urandom,
                    int'($urandom_range(0, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
